// File: rtl/mul4_vec_pkg.sv
// Shared types and helpers for the mul4 bit-plane vector packer.
// The checker enabled by MUL4_VEC_CHECK_EN uses mul2x2 through mul4_vec_lane_ref.
package mul4_vec_pkg;

  localparam int LANES_DEF = 16;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Unsigned 2x2 multiply; the 4-bit result can never overflow (max 3*3=9).
  function automatic logic [3:0] mul2x2(input logic [1:0] a, input logic [1:0] b);
    return {2'b00, a} * {2'b00, b};
  endfunction

endpackage

// File: rtl/mul4_vec_lane_ref.sv
// Combinational golden lane: one 2x2 unsigned product.
module mul4_vec_lane_ref
  import mul4_vec_pkg::*;
(
  input  logic [1:0] i_a,
  input  logic [1:0] i_b,
  output logic [3:0] o_p
);

  assign o_p = mul2x2(i_a, i_b);

endmodule

// File: rtl/mul4_vec_lane_packer.sv
// Transposes operand lanes into bit-planes for the candidate multiplier and
// serialises its product planes back out. Optional checker: MUL4_VEC_CHECK_EN.
module mul4_vec_lane_packer
  import mul4_vec_pkg::*;
#(
  parameter  int LANES = LANES_DEF,
  localparam int LW    = $clog2(LANES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_a,
  input  logic [1:0]       in_b,
  output logic             vec_valid,
  input  logic             vec_ready,
  output logic [LANES-1:0] a1,
  output logic [LANES-1:0] a0,
  output logic [LANES-1:0] b1,
  output logic [LANES-1:0] b0,
  input  logic [LANES-1:0] y3,
  input  logic [LANES-1:0] y2,
  input  logic [LANES-1:0] y1,
  input  logic [LANES-1:0] y0,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_p,
  output logic [LW-1:0]    out_lane
`ifdef MUL4_VEC_CHECK_EN
  ,
  output logic [LW:0]      err_cnt
`endif
);

  state_t           r_state, w_state_next;
  logic [LW-1:0]    r_k;
  logic [LANES-1:0] r_a1, r_a0, r_b1, r_b0;
  logic [LANES-1:0] r_y3, r_y2, r_y1, r_y0;
  logic             w_in_fire, w_vec_fire, w_out_fire, w_last;

  assign w_last = (r_k == LW'(LANES - 1));

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    vec_valid    = 1'b0;
    out_valid    = 1'b0;
    w_in_fire    = 1'b0;
    w_vec_fire   = 1'b0;
    w_out_fire   = 1'b0;
    unique case (r_state)
      FILL: begin
        in_ready  = 1'b1;
        w_in_fire = in_valid;
        if (in_valid && w_last) w_state_next = ISSUE;
      end
      ISSUE: begin
        vec_valid  = 1'b1;
        w_vec_fire = vec_ready;
        if (vec_ready) w_state_next = DRAIN;
      end
      DRAIN: begin
        out_valid  = 1'b1;
        w_out_fire = out_ready;
        if (out_ready && w_last) w_state_next = FILL;
      end
      default: w_state_next = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FILL;
      r_k     <= '0;
      r_a1    <= '0;
      r_a0    <= '0;
      r_b1    <= '0;
      r_b0    <= '0;
      r_y3    <= '0;
      r_y2    <= '0;
      r_y1    <= '0;
      r_y0    <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_in_fire) begin
        r_a1[r_k] <= in_a[1];
        r_a0[r_k] <= in_a[0];
        r_b1[r_k] <= in_b[1];
        r_b0[r_k] <= in_b[0];
      end
      // The lane counter is shared by FILL and DRAIN; only one phase fires per cycle.
      if (w_in_fire || w_out_fire) r_k <= w_last ? '0 : r_k + LW'(1);
      if (w_vec_fire) begin
        r_y3 <= y3;
        r_y2 <= y2;
        r_y1 <= y1;
        r_y0 <= y0;
      end
    end
  end

  assign a1 = r_a1;
  assign a0 = r_a0;
  assign b1 = r_b1;
  assign b0 = r_b0;

  // Outputs read as zero outside DRAIN so the idle bus carries no stale lanes.
  assign out_p    = (r_state == DRAIN) ? {r_y3[r_k], r_y2[r_k], r_y1[r_k], r_y0[r_k]} : 4'd0;
  assign out_lane = (r_state == DRAIN) ? r_k : '0;

`ifdef MUL4_VEC_CHECK_EN
  logic [3:0] w_gold;
  logic [LW:0] r_err;

  mul4_vec_lane_ref u_ref (
    .i_a ({r_a1[r_k], r_a0[r_k]}),
    .i_b ({r_b1[r_k], r_b0[r_k]}),
    .o_p (w_gold)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= '0;
    end else if (w_in_fire && w_last) begin
      r_err <= '0;
    end else if (w_out_fire && (out_p != w_gold) && (r_err != (LW+1)'(LANES))) begin
      r_err <= r_err + (LW+1)'(1);
    end
  end

  assign err_cnt = r_err;
`endif

endmodule
